// File: rtl/cpu.sv
// Multi-cycle 16-bit load/store processor: instruction ROM, data RAM, 16x16 register file, ALU
// and a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with a terminal HALT state.
module cpu #(
    parameter int unsigned ROM_DEPTH = 256,
    parameter int unsigned RAM_DEPTH = 16,
    parameter int unsigned DATA_W    = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [7:0]  dbg_pc,
    output logic [2:0]  dbg_state,
    output logic [15:0] dbg_alu,
    output logic        halted
);

    localparam int unsigned NUM_REGS = 16;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_NOT   = 4'h6;
    localparam logic [3:0] OP_SHL   = 4'h7;
    localparam logic [3:0] OP_SHR   = 4'h8;
    localparam logic [3:0] OP_LOAD  = 4'h9;
    localparam logic [3:0] OP_STORE = 4'hA;
    localparam logic [3:0] OP_LDI   = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_BEQ   = 4'hD;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Program and data storage; contents are preloaded externally and never reset.
    logic [DATA_W-1:0] rom_mem [ROM_DEPTH];
    logic [DATA_W-1:0] ram_mem [RAM_DEPTH];

    state_t            state_q, state_d;
    logic [7:0]        pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] src1_q, src1_d;
    logic [DATA_W-1:0] src2_q, src2_d;
    logic [DATA_W-1:0] destval_q, destval_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic              rf_we_c;
    logic [DATA_W-1:0] rf_wdata_c;
    logic              ram_we_c;
    logic [DATA_W-1:0] alu_result_c;

    logic [3:0] opcode, dest, sel1, sel2;
    logic [7:0] imm8;

    assign opcode = ir_q[15:12];
    assign dest   = ir_q[11:8];
    assign sel1   = ir_q[7:4];
    assign sel2   = ir_q[3:0];
    assign imm8   = ir_q[7:0];

    // ALU: shift amounts come from the raw select2 field, not a register.
    always_comb begin
        alu_result_c = '0;
        case (opcode)
            OP_ADD:   alu_result_c = src1_q + src2_q;
            OP_SUB:   alu_result_c = src1_q - src2_q;
            OP_AND:   alu_result_c = src1_q & src2_q;
            OP_OR:    alu_result_c = src1_q | src2_q;
            OP_XOR:   alu_result_c = src1_q ^ src2_q;
            OP_NOT:   alu_result_c = ~src1_q;
            OP_SHL:   alu_result_c = src1_q << sel2;
            OP_SHR:   alu_result_c = src1_q >> sel2;
            OP_LOAD,
            OP_STORE: alu_result_c = src1_q;
            OP_LDI,
            OP_JMP:   alu_result_c = DATA_W'(imm8);
            default:  alu_result_c = '0;
        endcase
    end

    // Sequencer next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        destval_d  = destval_q;
        alu_d      = alu_q;
        mdr_d      = mdr_q;
        halted_d   = halted_q;
        rf_we_c    = 1'b0;
        rf_wdata_c = '0;
        ram_we_c   = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_d    = rom_mem[pc_q];
                pc_d    = pc_q + 8'd1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                src1_d    = regs_q[sel1];
                src2_d    = regs_q[sel2];
                destval_d = regs_q[dest];
                state_d   = S_EXECUTE;
            end
            S_EXECUTE: begin
                alu_d   = alu_result_c;
                state_d = S_WRITEBACK;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMORY;
                    OP_JMP:            pc_d = imm8;
                    OP_BEQ: begin
                        // Offset is relative to the already-incremented pc.
                        if (destval_q == src1_q) begin
                            pc_d = pc_q + {{4{sel2[3]}}, sel2};
                        end
                    end
                    OP_HALT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEMORY: begin
                if (opcode == OP_LOAD) begin
                    mdr_d = ram_mem[src1_q[3:0]];
                end
                if (opcode == OP_STORE) begin
                    ram_we_c = 1'b1;
                end
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                if (opcode >= OP_ADD && opcode <= OP_SHR) begin
                    rf_we_c    = 1'b1;
                    rf_wdata_c = alu_q;
                end else if (opcode == OP_LOAD) begin
                    rf_we_c    = 1'b1;
                    rf_wdata_c = mdr_q;
                end else if (opcode == OP_LDI) begin
                    rf_we_c    = 1'b1;
                    rf_wdata_c = alu_q;
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            destval_q <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            halted_q  <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            destval_q <= destval_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            halted_q  <= halted_d;
            if (rf_we_c) begin
                regs_q[dest] <= rf_wdata_c;
            end
        end
    end

    // Data RAM write port; only ever enabled from MEMORY, which reset leaves immediately.
    always_ff @(posedge clock) begin
        if (ram_we_c) begin
            ram_mem[src1_q[3:0]] <= destval_q;
        end
    end

    assign dbg_pc    = pc_q;
    assign dbg_state = state_q;
    assign dbg_alu   = alu_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: preloads ROM/RAM, releases reset and checks registers, RAM,
// debug outputs and cycle timing against hand-computed values.
module tb_cpu;

    logic        clock;
    logic        reset_n;
    logic [7:0]  dbg_pc;
    logic [2:0]  dbg_state;
    logic [15:0] dbg_alu;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    cpu dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .dbg_pc    (dbg_pc),
        .dbg_state (dbg_state),
        .dbg_alu   (dbg_alu),
        .halted    (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Hold reset, fill the ROM with HALT so a runaway program stops.
    task automatic hold_reset_clear_rom();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 256; i++) dut.rom_mem[i] = 16'hF000;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;

        // Reset/ALU program
        hold_reset_clear_rom();
        chk("rst_pc", 16'(dbg_pc), 16'h0000);
        chk("rst_state", 16'(dbg_state), 16'h0000);
        chk("rst_alu", dbg_alu, 16'h0000);
        chk("rst_halted", 16'(halted), 16'h0000);
        chk("rst_r0", dut.regs_q[0], 16'h0000);
        dut.rom_mem[0] = 16'hB105;
        dut.rom_mem[1] = 16'hB203;
        dut.rom_mem[2] = 16'h1312;
        dut.rom_mem[3] = 16'h2412;
        dut.rom_mem[4] = 16'hF000;
        release_reset();
        tick(11);
        chk("add_r3_before_wb", dut.regs_q[3], 16'h0000);
        chk("add_alu", dbg_alu, 16'h0008);
        chk("add_state_wb", 16'(dbg_state), 16'h0004);
        tick(1);
        chk("add_r3_at_12", dut.regs_q[3], 16'h0008);
        chk("add_state_fetch", 16'(dbg_state), 16'h0000);
        tick(4);
        chk("sub_r4", dut.regs_q[4], 16'h0002);
        tick(3);
        chk("halt_flag", 16'(halted), 16'h0001);
        chk("halt_pc", 16'(dbg_pc), 16'h0005);
        chk("halt_state", 16'(dbg_state), 16'h0005);
        tick(20);
        chk("hold_pc", 16'(dbg_pc), 16'h0005);
        chk("hold_state", 16'(dbg_state), 16'h0005);
        chk("hold_r3", dut.regs_q[3], 16'h0008);
        chk("hold_r4", dut.regs_q[4], 16'h0002);
        chk("hold_halted", 16'(halted), 16'h0001);

        // Memory program: LOAD from RAM[4], STORE into RAM[9]
        hold_reset_clear_rom();
        dut.ram_mem[4] = 16'hBEEF;
        dut.ram_mem[9] = 16'h0000;
        dut.rom_mem[0] = 16'hB104;
        dut.rom_mem[1] = 16'h9210;
        dut.rom_mem[2] = 16'hB309;
        dut.rom_mem[3] = 16'hA230;
        dut.rom_mem[4] = 16'hF000;
        release_reset();
        tick(7);
        chk("load_state_mem", 16'(dbg_state), 16'h0003);
        chk("load_alu_addr", dbg_alu, 16'h0004);
        tick(1);
        chk("load_r2_before_wb", dut.regs_q[2], 16'h0000);
        tick(1);
        chk("load_r2", dut.regs_q[2], 16'hBEEF);
        tick(7);
        chk("store_ram9_before", dut.ram_mem[9], 16'h0000);
        tick(1);
        chk("store_ram9", dut.ram_mem[9], 16'hBEEF);
        tick(4);
        chk("mem_halt_flag", 16'(halted), 16'h0001);
        chk("mem_halt_pc", 16'(dbg_pc), 16'h0005);
        chk("mem_ram4_kept", dut.ram_mem[4], 16'hBEEF);

        // Logic/shift program
        hold_reset_clear_rom();
        dut.rom_mem[0] = 16'hB1F0;
        dut.rom_mem[1] = 16'h7214;
        dut.rom_mem[2] = 16'h8318;
        dut.rom_mem[3] = 16'h6410;
        dut.rom_mem[4] = 16'hB601;
        dut.rom_mem[5] = 16'h2506;
        dut.rom_mem[6] = 16'h5711;
        dut.rom_mem[7] = 16'h3812;
        dut.rom_mem[8] = 16'h4912;
        dut.rom_mem[9] = 16'hF000;
        release_reset();
        tick(39);
        chk("shl_r2", dut.regs_q[2], 16'h0F00);
        chk("shr_r3", dut.regs_q[3], 16'h0000);
        chk("not_r4", dut.regs_q[4], 16'hFF0F);
        chk("sub_wrap_r5", dut.regs_q[5], 16'hFFFF);
        chk("xor_r7", dut.regs_q[7], 16'h0000);
        chk("and_r8", dut.regs_q[8], 16'h0000);
        chk("or_r9", dut.regs_q[9], 16'h0FF0);
        chk("logic_halted", 16'(halted), 16'h0001);
        chk("logic_pc", 16'(dbg_pc), 16'h000A);

        // Branch program: taken BEQ skips two, untaken BEQ falls through
        hold_reset_clear_rom();
        dut.rom_mem[0] = 16'hB107;
        dut.rom_mem[1] = 16'hB207;
        dut.rom_mem[2] = 16'hD122;
        dut.rom_mem[3] = 16'hB3AA;
        dut.rom_mem[4] = 16'hB4BB;
        dut.rom_mem[5] = 16'hB5CC;
        dut.rom_mem[6] = 16'hB601;
        dut.rom_mem[7] = 16'hD613;
        dut.rom_mem[8] = 16'hB777;
        dut.rom_mem[9] = 16'hF000;
        release_reset();
        tick(11);
        chk("beq_taken_pc", 16'(dbg_pc), 16'h0005);
        tick(20);
        chk("beq_skip_r3", dut.regs_q[3], 16'h0000);
        chk("beq_skip_r4", dut.regs_q[4], 16'h0000);
        chk("beq_land_r5", dut.regs_q[5], 16'h00CC);
        chk("beq_fall_r7", dut.regs_q[7], 16'h0077);
        chk("beq_halt_pc", 16'(dbg_pc), 16'h000A);
        chk("beq_halted", 16'(halted), 16'h0001);

        // JMP loop through 0xFF, pc wraps to 0 on fetch
        hold_reset_clear_rom();
        dut.rom_mem[0]   = 16'hC0FF;
        dut.rom_mem[255] = 16'h0000;
        release_reset();
        tick(3);
        chk("jmp_pc_ff", 16'(dbg_pc), 16'h00FF);
        tick(2);
        chk("wrap_pc_00", 16'(dbg_pc), 16'h0000);
        tick(6);
        chk("loop_pc_ff", 16'(dbg_pc), 16'h00FF);
        chk("loop_state", 16'(dbg_state), 16'h0004);
        chk("loop_not_halted", 16'(halted), 16'h0000);

        // Reset asserted while the ADD is in EXECUTE
        hold_reset_clear_rom();
        dut.rom_mem[0] = 16'hB105;
        dut.rom_mem[1] = 16'hB203;
        dut.rom_mem[2] = 16'h1312;
        dut.rom_mem[3] = 16'hF000;
        release_reset();
        tick(10);
        chk("mid_state_exec", 16'(dbg_state), 16'h0002);
        chk("mid_alu_pre", dbg_alu, 16'h0003);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_pc", 16'(dbg_pc), 16'h0000);
        chk("mid_rst_state", 16'(dbg_state), 16'h0000);
        chk("mid_rst_alu", dbg_alu, 16'h0000);
        chk("mid_rst_r1", dut.regs_q[1], 16'h0000);
        chk("mid_rst_r3", dut.regs_q[3], 16'h0000);
        chk("mid_ram_kept", dut.ram_mem[9], 16'hBEEF);
        release_reset();
        tick(11);
        chk("restart_r3_before", dut.regs_q[3], 16'h0000);
        tick(1);
        chk("restart_r3", dut.regs_q[3], 16'h0008);
        tick(3);
        chk("restart_halted", 16'(halted), 16'h0001);
        chk("restart_pc", 16'(dbg_pc), 16'h0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
